rw_flow_ctrl_burst: RTL and testbench

Second-generation read/write/transmit flow controller. Accepts one command at a time: memory read, memory write, or transmit-only. Each command is a burst of 1..2^LEN_W beats with address auto-increment and a parametrised memory read latency. Sits between the command decoder and the memory/serial-TX blocks, driving memory strobes, the sample strobe and tx_start, and reporting busy, done and error.

---
 rtl/rw_flow_ctrl_burst_pkg.sv | 27 ++
 rtl/rw_flow_ctrl_burst_if.sv | 34 +++
 rtl/rw_flow_ctrl_burst_timer.sv | 29 ++
 rtl/rw_flow_ctrl_burst.sv | 137 +++++++++++++
 tb/tb_rw_flow_ctrl_burst.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rw_flow_ctrl_burst_pkg.sv
// Shared types and constants for the burst read/write/transmit flow controller.
// One-hot state encoding, command field encodings and a small sizing helper.
package rw_flow_pkg;

   localparam int STATE_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 8'b0000_0001,
      ST_MEM_ACC  = 8'b0000_0010,
      ST_MEM_WAIT = 8'b0000_0100,
      ST_SAMPLE   = 8'b0000_1000,
      ST_TX_START = 8'b0001_0000,
      ST_TX_WAIT  = 8'b0010_0000,
      ST_WR_BEAT  = 8'b0100_0000,
      ST_DONE     = 8'b1000_0000
   } state_t;

   localparam logic MODE_MEM = 1'b1;
   localparam logic MODE_TX  = 1'b0;
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rw_flow_ctrl_burst_if.sv
// Command, memory-strobe and TX-control bus between the command decoder side
// (master) and the flow controller (slave).
interface rw_flow_ctrl_burst_if #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
);
   logic              active;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_mode;
   logic              cmd_rw;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wr_valid;
   logic              tx_done;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              sample_data;
   logic              tx_start;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      output active, cmd_valid, cmd_mode, cmd_rw, cmd_addr, cmd_len, wr_valid, tx_done,
      input  cmd_ready, mem_en, mem_we, mem_addr, sample_data, tx_start, busy, done, error
   );

   modport slave (
      input  active, cmd_valid, cmd_mode, cmd_rw, cmd_addr, cmd_len, wr_valid, tx_done,
      output cmd_ready, mem_en, mem_we, mem_addr, sample_data, tx_start, busy, done, error
   );
endinterface

// File: rtl/rw_flow_ctrl_burst_timer.sv
// Loadable down-counter with zero flag; shared by the memory-latency wait and
// the optional TX timeout. Load has priority over decrement; it stops at zero.
module rw_flow_timer
   import rw_flow_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rw_flow_ctrl_burst.sv
// Burst read/write/transmit flow controller: one command at a time, Moore strobes.
// Optional TX_WAIT abort after TX_TIMEOUT cycles when TX_TIMEOUT_EN is defined.
module rw_flow_ctrl_burst
   import rw_flow_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int LEN_W      = 4,
   parameter int MEM_LAT    = 2,
   parameter int TX_TIMEOUT = 1024
) (
   input logic                clk,
   input logic                reset,
   rw_flow_ctrl_burst_if.slave bus
);
   localparam int TMR_W       = $clog2(max_int(MEM_LAT, TX_TIMEOUT)) + 1;
   // MEM_WAIT spans MEM_LAT-1 cycles; the zero flag is seen in its final cycle.
   localparam int MEM_WAIT_LD = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

   state_t            r_state;
   logic              r_mode;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_beat;
   logic              r_error;

   logic              w_accept;
   logic              w_last;
   logic              w_abort;
   logic              w_timeout;
   logic              w_mem_en;
   logic              w_tmr_load;
   logic              w_tmr_dec;
   logic              w_tmr_zero;
   logic [TMR_W-1:0]  w_tmr_val;

   assign w_accept = (r_state == ST_IDLE) && bus.active && bus.cmd_valid;
   assign w_last   = (r_beat == r_len);
   assign w_abort  = !bus.active && (r_state != ST_IDLE) && (r_state != ST_DONE);

`ifdef TX_TIMEOUT_EN
   assign w_tmr_load = (r_state == ST_MEM_ACC) || (r_state == ST_TX_START);
   assign w_tmr_val  = (r_state == ST_TX_START) ? TMR_W'(TX_TIMEOUT - 1) : TMR_W'(MEM_WAIT_LD);
   // A tx_done arriving in the expiry cycle still completes the beat.
   assign w_timeout  = (r_state == ST_TX_WAIT) && w_tmr_zero && !bus.tx_done;
`else
   assign w_tmr_load = (r_state == ST_MEM_ACC);
   assign w_tmr_val  = TMR_W'(MEM_WAIT_LD);
   assign w_timeout  = 1'b0;
`endif
   assign w_tmr_dec  = (r_state == ST_MEM_WAIT) || (r_state == ST_TX_WAIT);

   rw_flow_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_TX;
         r_rw    <= RW_READ;
         r_addr  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_error <= 1'b0;
      end else if (w_abort) begin
         r_state <= ST_DONE;
         r_error <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_mode  <= bus.cmd_mode;
                  r_rw    <= bus.cmd_mode & bus.cmd_rw;
                  r_addr  <= bus.cmd_addr;
                  r_len   <= bus.cmd_len;
                  r_beat  <= '0;
                  r_error <= 1'b0;
                  if (bus.cmd_mode == MODE_TX)
                     r_state <= ST_SAMPLE;
                  else if (bus.cmd_rw == RW_WRITE)
                     r_state <= ST_WR_BEAT;
                  else
                     r_state <= ST_MEM_ACC;
               end
            end
            ST_MEM_ACC:  r_state <= (MEM_LAT > 1) ? ST_MEM_WAIT : ST_SAMPLE;
            ST_MEM_WAIT: if (w_tmr_zero) r_state <= ST_SAMPLE;
            ST_SAMPLE:   r_state <= ST_TX_START;
            ST_TX_START: r_state <= ST_TX_WAIT;
            ST_TX_WAIT: begin
               if (bus.tx_done) begin
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_addr  <= r_addr + ADDR_W'(1);
                     r_beat  <= r_beat + LEN_W'(1);
                     r_state <= (r_mode == MODE_MEM) ? ST_MEM_ACC : ST_SAMPLE;
                  end
               end else if (w_timeout) begin
                  r_state <= ST_DONE;
                  r_error <= 1'b1;
               end
            end
            ST_WR_BEAT: begin
               if (bus.wr_valid) begin
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_addr <= r_addr + ADDR_W'(1);
                     r_beat <= r_beat + LEN_W'(1);
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_mem_en        = (r_state == ST_MEM_ACC) || ((r_state == ST_WR_BEAT) && bus.wr_valid);
   assign bus.cmd_ready   = (r_state == ST_IDLE) && bus.active;
   assign bus.mem_en      = w_mem_en;
   assign bus.mem_we      = w_mem_en && r_rw;
   assign bus.mem_addr    = r_addr;
   assign bus.sample_data = (r_state == ST_SAMPLE);
   assign bus.tx_start    = (r_state == ST_TX_START);
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.done        = (r_state == ST_DONE);
   assign bus.error       = r_error;

endmodule

// File: tb/tb_rw_flow_ctrl_burst.sv
// Scoreboard bench for rw_flow_ctrl_burst: stimulus pushes expected strobe events
// with their cycle numbers; a negedge monitor pops and compares each strobe seen.
module tb_rw_flow_ctrl_burst;
   localparam int K_MEM = 0, K_SMP = 1, K_TXS = 2, K_DONE = 3;

   typedef struct {
      int         kind;
      logic [7:0] addr;
      logic       we;
      logic       err;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   acc_cnt = 0;
   ev_t  exp_q[$];

   rw_flow_ctrl_burst_if #(.ADDR_W(8), .LEN_W(4)) bus ();

   rw_flow_ctrl_burst #(
      .ADDR_W(8), .LEN_W(4), .MEM_LAT(2), .TX_TIMEOUT(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
   end

   function automatic string kname(input int k);
      case (k)
         K_MEM:   return "mem";
         K_SMP:   return "sample";
         K_TXS:   return "txstart";
         default: return "done";
      endcase
   endfunction

   task automatic expect_ev(input int kind, input logic [7:0] addr, input logic we,
                            input logic err, input int c);
      ev_t e;
      e.kind = kind; e.addr = addr; e.we = we; e.err = err; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input int kind);
      ev_t e;
      bit  ok;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s: got event at cyc=%0d addr=%h, required no event",
                  kname(kind), cyc, bus.mem_addr);
         return;
      end
      e = exp_q.pop_front();
      ok = (e.kind == kind) && (e.cyc == cyc);
      if (kind == K_MEM)  ok = ok && (bus.mem_addr == e.addr) && (bus.mem_we == e.we);
      if (kind == K_DONE) ok = ok && (bus.error == e.err);
      if (!ok) begin
         bad++;
         $display("FAIL ev_%s: got %s cyc=%0d addr=%h we=%b err=%b, required %s cyc=%0d addr=%h we=%b err=%b",
                  kname(e.kind), kname(kind), cyc, bus.mem_addr, bus.mem_we, bus.error,
                  kname(e.kind), e.cyc, e.addr, e.we, e.err);
      end else begin
         $display("ok   ev_%s cyc=%0d addr=%h we=%b err=%b",
                  kname(kind), cyc, bus.mem_addr, bus.mem_we, bus.error);
      end
   endtask

   always @(negedge clk) begin
      if (bus.mem_en)      check_ev(K_MEM);
      if (bus.sample_data) check_ev(K_SMP);
      if (bus.tx_start)    check_ev(K_TXS);
      if (bus.done)        check_ev(K_DONE);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_tx(input int c);
      wait_until(c);
      bus.tx_done = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns #1 after the accepting edge with cmd_valid still high; b = first burst cycle.
   task automatic issue(input logic mode, input logic rw, input logic [7:0] addr,
                        input logic [3:0] len, output int b);
      int n;
      n = 0;
      bus.cmd_mode  = mode;
      bus.cmd_rw    = rw;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got cmd_ready=0 after 50 cycles, required 1");
      end
      @(posedge clk);
      #1;
      b = cyc;
   endtask

   function automatic logic [14:0] outs();
      return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.sample_data, bus.tx_start,
              bus.busy, bus.done, bus.error};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000ns, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int exp_acc;
      int wv[6];
      wv = '{1, 0, 0, 1, 1, 1};
      exp_acc = 0;
      reset = 1'b1;
      bus.active = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_mode = 1'b0;
      bus.cmd_rw = 1'b0;
      bus.cmd_addr = '0;
      bus.cmd_len = '0;
      bus.wr_valid = 1'b0;
      bus.tx_done = 1'b0;
      #12;
      chk("reset_outputs", 32'(outs()), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);

      // Read, len 0: mem_en, one MEM_WAIT, sample, tx_start, done after tx_done.
      issue(1'b1, 1'b0, 8'h10, 4'd0, a);
      bus.cmd_valid = 1'b0;
      exp_acc++;
      expect_ev(K_MEM,  8'h10, 1'b0, 1'b0, a);
      expect_ev(K_SMP,  8'h00, 1'b0, 1'b0, a + 2);
      expect_ev(K_TXS,  8'h00, 1'b0, 1'b0, a + 3);
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, a + 7);
      pulse_tx(a + 6);
      wait_until(a + 7);
      chk("t1_busy_in_done", 32'(bus.busy), 32'h1);
      wait_until(a + 8);
      chk("t1_busy_after_done", 32'(bus.busy), 32'h0);
      idle(2);

      // Write with address wrap and a two-cycle stall on the second beat.
      issue(1'b1, 1'b1, 8'hFE, 4'd3, a);
      bus.cmd_valid = 1'b0;
      exp_acc++;
      expect_ev(K_MEM,  8'hFE, 1'b1, 1'b0, a);
      expect_ev(K_MEM,  8'hFF, 1'b1, 1'b0, a + 3);
      expect_ev(K_MEM,  8'h00, 1'b1, 1'b0, a + 4);
      expect_ev(K_MEM,  8'h01, 1'b1, 1'b0, a + 5);
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, a + 6);
      for (int i = 0; i < 6; i++) begin
         bus.wr_valid = wv[i][0];
         @(posedge clk);
         #1;
      end
      bus.wr_valid = 1'b0;
      idle(2);

      // Transmit-only, len 2, cmd_valid held; tx_done during TX_START is ignored.
      issue(1'b0, 1'b0, 8'h40, 4'd2, a);
      exp_acc++;
      for (int k = 0; k < 3; k++) begin
         expect_ev(K_SMP, 8'h00, 1'b0, 1'b0, a + 4 * k);
         expect_ev(K_TXS, 8'h00, 1'b0, 1'b0, a + 4 * k + 1);
      end
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, a + 12);
      pulse_tx(a + 1);
      pulse_tx(a + 3);
      wait_until(a + 5);
      chk("t3_ready_low_busy", 32'(bus.cmd_ready), 32'h0);
      pulse_tx(a + 7);
      pulse_tx(a + 11);
      bus.cmd_valid = 1'b0;
      idle(2);

      // Read len 5, active dropped in TX_WAIT of the second beat.
      issue(1'b1, 1'b0, 8'h20, 4'd5, a);
      bus.cmd_valid = 1'b0;
      exp_acc++;
      expect_ev(K_MEM,  8'h20, 1'b0, 1'b0, a);
      expect_ev(K_SMP,  8'h00, 1'b0, 1'b0, a + 2);
      expect_ev(K_TXS,  8'h00, 1'b0, 1'b0, a + 3);
      expect_ev(K_MEM,  8'h21, 1'b0, 1'b0, a + 6);
      expect_ev(K_SMP,  8'h00, 1'b0, 1'b0, a + 8);
      expect_ev(K_TXS,  8'h00, 1'b0, 1'b0, a + 9);
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b1, a + 12);
      pulse_tx(a + 5);
      wait_until(a + 11);
      bus.active = 1'b0;
      wait_until(a + 13);
      bus.active = 1'b1;
      chk("t4_error_sticky", 32'(bus.error), 32'h1);
      chk("t4_idle_after_abort", 32'(bus.busy), 32'h0);
      idle(2);

      // Next accepted command clears the error flag.
      issue(1'b0, 1'b0, 8'h00, 4'd0, a);
      bus.cmd_valid = 1'b0;
      exp_acc++;
      chk("t5_error_cleared", 32'(bus.error), 32'h0);
      expect_ev(K_SMP,  8'h00, 1'b0, 1'b0, a);
      expect_ev(K_TXS,  8'h00, 1'b0, 1'b0, a + 1);
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, a + 3);
      pulse_tx(a + 2);
      wait_until(a + 4);
      idle(2);

      // Maximum burst (16 beats) back-to-back write across the address wrap.
      issue(1'b1, 1'b1, 8'hF8, 4'd15, a);
      bus.cmd_valid = 1'b0;
      bus.wr_valid = 1'b1;
      exp_acc++;
      for (int i = 0; i < 16; i++)
         expect_ev(K_MEM, 8'(8'hF8 + i), 1'b1, 1'b0, a + i);
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, a + 16);
      wait_until(a + 16);
      bus.wr_valid = 1'b0;
      idle(2);

`ifdef TX_TIMEOUT_EN
      // Timeout with no tx_done: DONE at TX_WAIT entry + 16 with error.
      issue(1'b0, 1'b0, 8'h33, 4'd0, a);
      bus.cmd_valid = 1'b0;
      exp_acc++;
      expect_ev(K_SMP,  8'h00, 1'b0, 1'b0, a);
      expect_ev(K_TXS,  8'h00, 1'b0, 1'b0, a + 1);
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b1, a + 18);
      wait_until(a + 19);
      chk("t6_timeout_error", 32'(bus.error), 32'h1);
      idle(2);

      // tx_done in the expiry cycle wins: normal completion.
      issue(1'b0, 1'b0, 8'h34, 4'd0, a);
      bus.cmd_valid = 1'b0;
      exp_acc++;
      expect_ev(K_SMP,  8'h00, 1'b0, 1'b0, a);
      expect_ev(K_TXS,  8'h00, 1'b0, 1'b0, a + 1);
      expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, a + 18);
      pulse_tx(a + 17);
      wait_until(a + 19);
      chk("t7_no_timeout_error", 32'(bus.error), 32'h0);
      idle(2);
`endif

      // Asynchronous reset in the middle of a write burst.
      issue(1'b1, 1'b1, 8'h80, 4'd7, a);
      bus.cmd_valid = 1'b0;
      bus.wr_valid = 1'b1;
      exp_acc++;
      expect_ev(K_MEM, 8'h80, 1'b1, 1'b0, a);
      expect_ev(K_MEM, 8'h81, 1'b1, 1'b0, a + 1);
      wait_until(a + 2);
      reset = 1'b1;
      #1;
      chk("t8_async_reset_outputs", 32'(outs()), 32'h0);
      bus.wr_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(4);
      chk("t8_idle_after_reset", 32'(bus.cmd_ready), 32'h1);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      chk("accept_count", 32'(acc_cnt), 32'(exp_acc));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
